// File: rtl/hazard_pkg.sv
// Shared defaults for the tProc control-pipeline hazard logic.
// Optional stall counter in t_ctrl_hazard_sb is enabled by HAZARD_STALL_CNT_EN.
package hazard_pkg;

    localparam int unsigned AW_DEF = 7;
    localparam int unsigned DW_DEF = 32;

    // Youngest in-flight stage; forwarding priority starts here.
    localparam int unsigned X1_ST  = 0;

endpackage

// File: rtl/t_hz_fwd_mux.sv
// Per-port operand select: in-flight stages (youngest first), write-back,
// pending long write, then register file. Flags a stall when data is not ready.
module t_hz_fwd_mux
    import hazard_pkg::*;
#(
    parameter int unsigned N_ST = 2,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic [AW-1:0]      rs_addr,
    input  logic [DW-1:0]      rs_dt,
    input  logic [N_ST-1:0]    st_we,
    input  logic [N_ST*AW-1:0] st_addr,
    input  logic [N_ST-1:0]    st_rdy,
    input  logic [N_ST*DW-1:0] st_dt,
    input  logic               wr_we,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DW-1:0]      wr_dt,
    input  logic               pend,
    output logic [DW-1:0]      sel_dt,
    output logic               stall
);

    logic hit;

    always_comb begin
        hit    = 1'b0;
        sel_dt = rs_dt;
        stall  = 1'b0;
        for (int unsigned s = X1_ST; s < N_ST; s++) begin
            if (!hit && st_we[s] && (st_addr[s*AW +: AW] == rs_addr)) begin
                hit = 1'b1;
                if (st_rdy[s]) begin
                    sel_dt = st_dt[s*DW +: DW];
                end else begin
                    stall = 1'b1;
                end
            end
        end
        if (!hit && wr_we && (wr_addr == rs_addr)) begin
            hit    = 1'b1;
            sel_dt = wr_dt;
        end
        // A matching write-back already carries the long write's data.
        if (!hit && pend) begin
            stall = 1'b1;
        end
    end

endmodule

// File: rtl/t_ctrl_hazard_sb.sv
// Forwarding/hazard unit with pending-write scoreboard and timed flag window.
// Define HAZARD_STALL_CNT_EN to add cnt_clr_i/stall_cnt_o saturating bubble counter.
module t_ctrl_hazard_sb
    import hazard_pkg::*;
#(
    parameter int unsigned N_RS     = 2,
    parameter int unsigned N_ST     = 2,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned FLAG_LAT = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               hold_i,
    input  logic [N_RS*AW-1:0] rs_addr_i,
    input  logic [N_RS*DW-1:0] rs_dt_i,
    input  logic [N_ST-1:0]    st_we_i,
    input  logic [N_ST*AW-1:0] st_addr_i,
    input  logic [N_ST-1:0]    st_rdy_i,
    input  logic [N_ST*DW-1:0] st_dt_i,
    input  logic               wr_we_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [DW-1:0]      wr_dt_i,
    input  logic               lw_issue_i,
    input  logic [AW-1:0]      lw_addr_i,
    input  logic               lw_done_i,
    input  logic [AW-1:0]      lw_done_addr_i,
    input  logic               flag_we_i,
    input  logic               id_flag_used_i,
    output logic [N_RS*DW-1:0] reg_dt_o,
    output logic               bubble_rd_o,
    output logic               bubble_id_o
`ifdef HAZARD_STALL_CNT_EN
    ,
    input  logic               cnt_clr_i,
    output logic [31:0]        stall_cnt_o
`endif
);

    localparam int unsigned NREG = 1 << AW;
    localparam int unsigned FW   = (FLAG_LAT > 0) ? $clog2(FLAG_LAT + 1) : 1;

    logic [NREG-1:0]    pend_q;
    logic [NREG-1:0]    pend_d;
    logic [N_RS*DW-1:0] sel_all;
    logic [N_RS-1:0]    stall;
    logic               waw;
    logic [FW-1:0]      flag_cnt_q;

    // Operand select per read port
    for (genvar k = 0; k < N_RS; k++) begin : g_port
        t_hz_fwd_mux #(
            .N_ST (N_ST),
            .AW   (AW),
            .DW   (DW)
        ) u_mux (
            .rs_addr (rs_addr_i[k*AW +: AW]),
            .rs_dt   (rs_dt_i[k*DW +: DW]),
            .st_we   (st_we_i),
            .st_addr (st_addr_i),
            .st_rdy  (st_rdy_i),
            .st_dt   (st_dt_i),
            .wr_we   (wr_we_i),
            .wr_addr (wr_addr_i),
            .wr_dt   (wr_dt_i),
            .pend    (pend_q[rs_addr_i[k*AW +: AW]]),
            .sel_dt  (sel_all[k*DW +: DW]),
            .stall   (stall[k])
        );
    end

    // Set after clear so issue+done to one address leaves the bit pending.
    always_comb begin
        pend_d = pend_q;
        if (lw_done_i) begin
            pend_d[lw_done_addr_i] = 1'b0;
        end
        if (lw_issue_i) begin
            pend_d[lw_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // An in-flight write to a pending register must not overtake the long write.
    always_comb begin
        waw = 1'b0;
        for (int unsigned s = 0; s < N_ST; s++) begin
            if (st_we_i[s] && pend_q[st_addr_i[s*AW +: AW]]) begin
                waw = 1'b1;
            end
        end
    end

    assign bubble_rd_o = (|stall) | waw;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_dt_o <= '0;
        end else if (!hold_i) begin
            reg_dt_o <= sel_all;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flag_cnt_q <= '0;
        end else if (flag_we_i) begin
            flag_cnt_q <= FW'(FLAG_LAT);
        end else if (flag_cnt_q != '0) begin
            flag_cnt_q <= flag_cnt_q - 1'b1;
        end
    end

    assign bubble_id_o = id_flag_used_i & (flag_we_i | (flag_cnt_q != '0));

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt_o <= '0;
        end else if ((bubble_rd_o | bubble_id_o) && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_t_ctrl_hazard_sb.sv
// Scoreboard bench for t_ctrl_hazard_sb: directed stimulus queues expectations,
// a negedge monitor pops and compares them when their cycle comes due.
module tb_t_ctrl_hazard_sb;

    localparam int unsigned N_RS     = 2;
    localparam int unsigned N_ST     = 2;
    localparam int unsigned AW       = 7;
    localparam int unsigned DW       = 32;
    localparam int unsigned FLAG_LAT = 2;

    logic               clk;
    logic               rst_ni;
    logic               hold_i;
    logic [N_RS*AW-1:0] rs_addr_i;
    logic [N_RS*DW-1:0] rs_dt_i;
    logic [N_ST-1:0]    st_we_i;
    logic [N_ST*AW-1:0] st_addr_i;
    logic [N_ST-1:0]    st_rdy_i;
    logic [N_ST*DW-1:0] st_dt_i;
    logic               wr_we_i;
    logic [AW-1:0]      wr_addr_i;
    logic [DW-1:0]      wr_dt_i;
    logic               lw_issue_i;
    logic [AW-1:0]      lw_addr_i;
    logic               lw_done_i;
    logic [AW-1:0]      lw_done_addr_i;
    logic               flag_we_i;
    logic               id_flag_used_i;
    logic [N_RS*DW-1:0] reg_dt_o;
    logic               bubble_rd_o;
    logic               bubble_id_o;
`ifdef HAZARD_STALL_CNT_EN
    logic               cnt_clr_i;
    logic [31:0]        stall_cnt_o;
`endif

    t_ctrl_hazard_sb #(
        .N_RS     (N_RS),
        .N_ST     (N_ST),
        .AW       (AW),
        .DW       (DW),
        .FLAG_LAT (FLAG_LAT)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .hold_i         (hold_i),
        .rs_addr_i      (rs_addr_i),
        .rs_dt_i        (rs_dt_i),
        .st_we_i        (st_we_i),
        .st_addr_i      (st_addr_i),
        .st_rdy_i       (st_rdy_i),
        .st_dt_i        (st_dt_i),
        .wr_we_i        (wr_we_i),
        .wr_addr_i      (wr_addr_i),
        .wr_dt_i        (wr_dt_i),
        .lw_issue_i     (lw_issue_i),
        .lw_addr_i      (lw_addr_i),
        .lw_done_i      (lw_done_i),
        .lw_done_addr_i (lw_done_addr_i),
        .flag_we_i      (flag_we_i),
        .id_flag_used_i (id_flag_used_i),
        .reg_dt_o       (reg_dt_o),
        .bubble_rd_o    (bubble_rd_o),
        .bubble_id_o    (bubble_id_o)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .cnt_clr_i      (cnt_clr_i),
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        int          tag;
    } item_t;

    item_t q[$];
    int    cyc      = 0;
    int    checks   = 0;
    int    failures = 0;
    int    tag      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 bubble_rd, 1 bubble_id, 2 reg_dt port0, 3 reg_dt port1
    task automatic push(input int kind, input logic [31:0] v, input int lag);
        item_t it;
        it.due  = cyc + lag;
        it.kind = kind;
        it.exp  = v;
        it.tag  = tag;
        q.push_back(it);
    endtask

    task automatic exp_rd(input logic v);                 push(0, {31'b0, v}, 0); endtask
    task automatic exp_id(input logic v);                 push(1, {31'b0, v}, 0); endtask
    task automatic exp_dt(input int p, input logic [31:0] v);     push(2 + p, v, 1); endtask
    task automatic exp_dt_now(input int p, input logic [31:0] v); push(2 + p, v, 0); endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        hold_i         = 1'b0;
        rs_addr_i      = {7'd6, 7'd1};
        rs_dt_i        = {32'h22, 32'h11};
        st_we_i        = '0;
        st_addr_i      = '0;
        st_rdy_i       = '0;
        st_dt_i        = '0;
        wr_we_i        = 1'b0;
        wr_addr_i      = '0;
        wr_dt_i        = '0;
        lw_issue_i     = 1'b0;
        lw_addr_i      = '0;
        lw_done_i      = 1'b0;
        lw_done_addr_i = '0;
        flag_we_i      = 1'b0;
        id_flag_used_i = 1'b0;
`ifdef HAZARD_STALL_CNT_EN
        cnt_clr_i      = 1'b0;
`endif
    endtask

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
                logic [31:0] act;
                string       nm;
                case (q[i].kind)
                    0:       begin act = {31'b0, bubble_rd_o}; nm = "bubble_rd"; end
                    1:       begin act = {31'b0, bubble_id_o}; nm = "bubble_id"; end
                    2:       begin act = reg_dt_o[31:0];       nm = "reg_dt0";   end
                    default: begin act = reg_dt_o[63:32];      nm = "reg_dt1";   end
                endcase
                checks++;
                if (q[i].due < cyc) begin
                    failures++;
                    $display("FAIL t%0d %s stale expectation due=%0d now=%0d", q[i].tag, nm, q[i].due, cyc);
                end else if (act !== q[i].exp) begin
                    failures++;
                    $display("FAIL t%0d %s got=0x%0h expected=0x%0h cyc=%0d", q[i].tag, nm, act, q[i].exp, cyc);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0;
        idle();
        step();
        tag = 0;
        exp_rd(1'b0); exp_id(1'b0); exp_dt_now(0, 32'h0); exp_dt_now(1, 32'h0);
        step();
        rst_ni = 1'b1;

        // stage 0 ready wins over stage 1
        step(); idle(); tag = 1;
        rs_addr_i[0 +: AW] = 7'd5;
        st_we_i = 2'b11; st_rdy_i = 2'b11;
        st_addr_i = {7'd5, 7'd5}; st_dt_i = {32'hBB, 32'hAA};
        exp_rd(1'b0); exp_dt(0, 32'hAA); exp_dt(1, 32'h22);

        // stage 0 not ready: stall even though stage 1 has data
        step(); tag = 2;
        st_rdy_i = 2'b10;
        exp_rd(1'b1); exp_dt(1, 32'h22);

        step(); tag = 3;
        st_we_i = 2'b10;
        exp_rd(1'b0); exp_dt(0, 32'hBB);

        // long write to 9
        step(); idle(); tag = 4;
        lw_issue_i = 1'b1; lw_addr_i = 7'd9;
        exp_rd(1'b0); exp_dt(0, 32'h11);
        for (int i = 0; i < 3; i++) begin
            step(); idle(); tag = 5;
            rs_addr_i[0 +: AW] = 7'd9;
            exp_rd(1'b1);
        end
        step(); idle(); tag = 6;
        rs_addr_i[0 +: AW] = 7'd9;
        lw_done_i = 1'b1; lw_done_addr_i = 7'd9;
        wr_we_i = 1'b1; wr_addr_i = 7'd9; wr_dt_i = 32'h1234;
        exp_rd(1'b0); exp_dt(0, 32'h1234);
        step(); idle(); tag = 7;
        rs_addr_i[0 +: AW] = 7'd9;
        exp_rd(1'b0); exp_dt(0, 32'h11);

        // write-after-write against pending 12
        step(); idle(); tag = 8;
        lw_issue_i = 1'b1; lw_addr_i = 7'd12;
        exp_rd(1'b0);
        step(); idle(); tag = 9;
        st_we_i = 2'b10; st_rdy_i = 2'b10; st_addr_i = {7'd12, 7'd0}; st_dt_i = {32'h77, 32'h0};
        exp_rd(1'b1); exp_dt(0, 32'h11);
        step(); idle(); tag = 10;
        lw_done_i = 1'b1; lw_done_addr_i = 7'd12;
        exp_rd(1'b0);

        // issue and done to the same address in one cycle
        step(); idle(); tag = 11;
        lw_issue_i = 1'b1; lw_addr_i = 7'd3;
        lw_done_i = 1'b1; lw_done_addr_i = 7'd3;
        exp_rd(1'b0);
        step(); idle(); tag = 12;
        rs_addr_i[AW +: AW] = 7'd3;
        exp_rd(1'b1);
        step(); idle(); tag = 13;
        rs_addr_i[AW +: AW] = 7'd3;
        lw_done_i = 1'b1; lw_done_addr_i = 7'd3;
        exp_rd(1'b1);
        step(); idle(); tag = 14;
        rs_addr_i[AW +: AW] = 7'd3;
        exp_rd(1'b0);

        // done on a clear bit has no effect
        step(); idle(); tag = 15;
        lw_done_i = 1'b1; lw_done_addr_i = 7'd20;
        step(); idle();
        rs_addr_i[0 +: AW] = 7'd20;
        exp_rd(1'b0);

        // flag window
        step(); idle(); tag = 16;
        flag_we_i = 1'b1;
        exp_id(1'b0);
        for (int i = 0; i < 3; i++) begin
            step(); idle(); tag = 17;
        end
        id_flag_used_i = 1'b1;
        exp_id(1'b0);
        step(); tag = 18;
        flag_we_i = 1'b1;
        exp_id(1'b1);
        step(); flag_we_i = 1'b0; exp_id(1'b1);
        step(); exp_id(1'b1);
        step(); tag = 19; exp_id(1'b0);

        // hold freezes the operand register
        step(); idle(); tag = 20;
        exp_dt(0, 32'h11);
        step(); tag = 21;
        hold_i = 1'b1; rs_dt_i[31:0] = 32'h55;
        exp_dt(0, 32'h11);
        step(); tag = 22;
        hold_i = 1'b0;
        exp_dt(0, 32'h55);

        // reset mid-operation clears scoreboard and flag counter
        step(); idle(); tag = 23;
        lw_issue_i = 1'b1; lw_addr_i = 7'd30; flag_we_i = 1'b1;
        step(); idle(); tag = 24;
        rst_ni = 1'b0;
        rs_addr_i[0 +: AW] = 7'd30; id_flag_used_i = 1'b1;
        exp_rd(1'b0); exp_id(1'b0); exp_dt_now(0, 32'h0); exp_dt_now(1, 32'h0);
        step(); tag = 25;
        rst_ni = 1'b1;
        exp_rd(1'b0); exp_id(1'b0); exp_dt(0, 32'h11);

        step(); idle();
        step();
        step();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/t_ctrl_hazard_sb.md
Name: t_ctrl_hazard_sb

Overview:
Parametrised forwarding and hazard unit for the tProc control pipeline, sitting between register-file read (RD) and execute.
- Forwards operand data for N_RS source ports from N_ST in-flight pipeline stages and the write-back port.
- Adds a pending-write scoreboard for variable-latency writes (external/port reads).
- Adds a timed flag-hazard window.
- Operand outputs are registered, with hold.

Parameters:
N_RS, 2, number of source-operand read ports
N_ST, 2, in-flight stages after RD (index 0 = X1, youngest)
AW, 7, register address width
DW, 32, data width
FLAG_LAT, 2, cycles after flag_we_i during which flag use is unsafe

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
hold_i  in  1  downstream stall; freeze output registers
rs_addr_i  in  N_RS*AW  source addresses, port k at [k*AW +: AW]
rs_dt_i  in  N_RS*DW  register-file read data
st_we_i  in  N_ST  stage s writes a register
st_addr_i  in  N_ST*AW  stage s destination address
st_rdy_i  in  N_ST  stage s result already available
st_dt_i  in  N_ST*DW  stage s result data
wr_we_i  in  1  write-back enable
wr_addr_i  in  AW  write-back address
wr_dt_i  in  DW  write-back data
lw_issue_i  in  1  long-latency write issued
lw_addr_i  in  AW  its destination
lw_done_i  in  1  long-latency write completes (same cycle as its register-file write)
lw_done_addr_i  in  AW  completed destination
flag_we_i  in  1  flag/time-condition being updated
id_flag_used_i  in  1  ID instruction reads flag
reg_dt_o  out  N_RS*DW  forwarded operands, registered
bubble_rd_o  out  1  insert bubble at RD (data not ready)
bubble_id_o  out  1  insert bubble at ID (flag window)

Behaviour:
- Reset values: reg_dt_o=0, scoreboard all clear, flag counter 0, both bubbles 0.
- Per-port selection, combinational; first match wins:
  1. Stages s=0..N_ST-1 with st_we_i[s] & addr match. If st_rdy_i[s], take st_dt_i[s]; else stall_k=1.
  2. wr_we_i & addr match: take wr_dt_i.
  3. Scoreboard bit pending for the address: stall_k=1.
  4. Otherwise take rs_dt_i.
- bubble_rd_o = OR of stall_k. It is combinational with a 0-cycle reaction.
- reg_dt_o latency is 1 cycle. It loads the selected value each cycle unless hold_i=1, in which case it holds. Stalled ports still load (value is don't-care).
- Scoreboard is a 2**AW bit vector:
  - lw_issue_i sets bit[lw_addr_i].
  - lw_done_i clears bit[lw_done_addr_i].
  - Issue and done to the same address in the same cycle: the bit stays set.
  - Issue to an already-pending address: the bit stays set.
  - lw_done_i on a clear bit: no effect.
- Write-after-write: if st_we_i[s] targets a pending address, bubble_rd_o=1. This keeps ordering with the long write.
- Flag counter (width clog2(FLAG_LAT+1)):
  - flag_we_i loads FLAG_LAT.
  - Otherwise it decrements while nonzero.
  - bubble_id_o = id_flag_used_i & (flag_we_i | counter!=0).
  - FLAG_LAT=0: only a same-cycle flag_we_i causes a bubble.
- Reset mid-operation clears all pending bits and the counter immediately. In-flight completions arriving after reset are ignored.

Optional Feature:
HAZARD_STALL_CNT_EN
- Defined:
  - Adds input cnt_clr_i (1).
  - Adds output stall_cnt_o (32), a saturating count of cycles with bubble_rd_o|bubble_id_o. It holds at 0xFFFFFFFF.
  - cnt_clr_i has priority: it zeroes the count that cycle, no increment.
  - Reset value is 0.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package: hazard_pkg holds default AW/DW and the stage-index constant X1_ST=0.
- One sub-module: t_hz_fwd_mux, the per-port priority select plus stall, instantiated N_RS times in a generate loop.

Test Plan:
- rs_addr port0=5. st_we_i[0]=1, st_addr 5, st_rdy 1, dt 0xAA. st_we_i[1]=1, st_addr 5, dt 0xBB. Expect reg_dt_o port0=0xAA next cycle, bubble_rd_o=0.
- Same, but st_rdy_i[0]=0. Expect bubble_rd_o=1 the same cycle. Then drop the stage-0 write; expect port0=0xBB.
- lw_issue_i addr 9, then read 9 for 3 cycles. Expect bubble_rd_o=1 each cycle. lw_done_i addr 9 together with wr_we_i addr 9, dt 0x1234: expect bubble 0 and reg_dt_o=0x1234 next cycle.
- Simultaneous lw_issue_i and lw_done_i, both addr 3. Expect bit 3 still pending; a read of 3 bubbles.
- flag_we_i pulse with FLAG_LAT=2, id_flag_used_i held 1. Expect bubble_id_o=1 for 3 cycles (pulse cycle plus 2), then 0.
- hold_i=1 while rs data changes: reg_dt_o is unchanged. Assert rst_ni=0 with bits pending: outputs 0 and scoreboard empty after release.
